// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: mem_ctrl bit positions and the memory-stage state encoding.
package pipeline_pkg;

    localparam int unsigned MC_READ  = 0;
    localparam int unsigned MC_WRITE = 1;
    localparam int unsigned MC_BYTE  = 2;
    localparam int unsigned MC_SEXT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERROR  = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_byte_align.sv
// Byte lane handling: selects and extends a read byte, replicates a store byte onto both lanes.
module mem_byte_align (
    input  logic [15:0] rdata,
    input  logic        addr_lsb,
    input  logic        rd_byte,
    input  logic        rd_sext,
    input  logic [15:0] wdata_in,
    input  logic        wr_byte,
    output logic [15:0] rdata_out,
    output logic [15:0] wdata_out
);
    logic [7:0] rd_sel;

    assign rd_sel    = addr_lsb ? rdata[15:8] : rdata[7:0];
    assign rdata_out = rd_byte ? {{8{rd_sext & rd_sel[7]}}, rd_sel} : rdata;

    // Each 8-bit lane carries either its own word byte or the low byte for byte stores.
    for (genvar gi = 0; gi < 2; gi++) begin : g_wlane
        assign wdata_out[gi*8 +: 8] = wr_byte ? wdata_in[7:0] : wdata_in[gi*8 +: 8];
    end
endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: passes non-memory instructions through in one cycle and runs a
// req/ack data-memory transaction (with timeout) for loads and stores.
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        in_valid,
    input  logic [15:0] wb_ctrl_in,
    input  logic [15:0] mem_ctrl_in,
    input  logic [15:0] alu_hi_in,
    input  logic [15:0] alu_lo_in,
    input  logic [15:0] store_data_in,
    input  logic [15:0] inst_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [15:0] wb_ctrl_out,
    output logic [15:0] mem_data_out,
    output logic [15:0] alu_hi_out,
    output logic [15:0] alu_lo_out,
    output logic [15:0] inst_out,
    output logic        out_valid,
    output logic        stall_out,
    output logic        mem_err
);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    mem_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d, stall_q, stall_d, err_q, err_d, valid_q, valid_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [15:0] wb_q, wb_d, md_q, md_d, hi_q, hi_d, lo_q, lo_d, inst_q, inst_d;
    // Instruction fields held while the memory access is outstanding.
    logic [15:0] wb_lat_q, wb_lat_d, hi_lat_q, hi_lat_d, inst_lat_q, inst_lat_d;
    logic        byte_lat_q, byte_lat_d, sext_lat_q, sext_lat_d, wr_lat_q, wr_lat_d;

    logic        is_wr, is_mem;
    logic [15:0] rd_aligned, wr_aligned;
    logic        unused_ctrl;

    assign is_wr       = mem_ctrl_in[MC_WRITE];
    assign is_mem      = is_wr | mem_ctrl_in[MC_READ];
    assign unused_ctrl = ^mem_ctrl_in[15:4];

    mem_byte_align u_align (
        .rdata     (dmem_rdata),
        .addr_lsb  (addr_q[0]),
        .rd_byte   (byte_lat_q),
        .rd_sext   (sext_lat_q),
        .wdata_in  (store_data_in),
        .wr_byte   (mem_ctrl_in[MC_BYTE]),
        .rdata_out (rd_aligned),
        .wdata_out (wr_aligned)
    );

    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;
        req_d = req_q;  we_d = we_q;  stall_d = stall_q;  err_d = err_q;
        valid_d = 1'b0;
        addr_d = addr_q;  wdata_d = wdata_q;
        wb_d = wb_q;  md_d = md_q;  hi_d = hi_q;  lo_d = lo_q;  inst_d = inst_q;
        wb_lat_d = wb_lat_q;  hi_lat_d = hi_lat_q;  inst_lat_d = inst_lat_q;
        byte_lat_d = byte_lat_q;  sext_lat_d = sext_lat_q;  wr_lat_d = wr_lat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && !halt) begin
                    if (is_mem) begin
                        state_d    = ST_ACCESS;
                        cnt_d      = 8'd0;
                        req_d      = 1'b1;
                        stall_d    = 1'b1;
                        we_d       = is_wr;
                        addr_d     = alu_lo_in;
                        wdata_d    = wr_aligned;
                        wb_lat_d   = wb_ctrl_in;
                        hi_lat_d   = alu_hi_in;
                        inst_lat_d = inst_in;
                        byte_lat_d = mem_ctrl_in[MC_BYTE];
                        sext_lat_d = mem_ctrl_in[MC_SEXT];
                        wr_lat_d   = is_wr;
                    end else begin
                        wb_d    = wb_ctrl_in;
                        md_d    = 16'h0000;
                        hi_d    = alu_hi_in;
                        lo_d    = alu_lo_in;
                        inst_d  = inst_in;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (dmem_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    stall_d = 1'b0;
                    valid_d = 1'b1;
                    wb_d    = wb_lat_q;
                    md_d    = wr_lat_q ? 16'h0000 : rd_aligned;
                    hi_d    = hi_lat_q;
                    lo_d    = addr_q;
                    inst_d  = inst_lat_q;
                end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
                    state_d = ST_ERROR;
                    cnt_d   = cnt_q + 8'd1;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ERROR: begin
                stall_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;  cnt_q <= 8'd0;
            req_q <= 1'b0;  we_q <= 1'b0;  stall_q <= 1'b0;  err_q <= 1'b0;  valid_q <= 1'b0;
            addr_q <= '0;  wdata_q <= '0;
            wb_q <= '0;  md_q <= '0;  hi_q <= '0;  lo_q <= '0;  inst_q <= '0;
            wb_lat_q <= '0;  hi_lat_q <= '0;  inst_lat_q <= '0;
            byte_lat_q <= 1'b0;  sext_lat_q <= 1'b0;  wr_lat_q <= 1'b0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;
            req_q <= req_d;  we_q <= we_d;  stall_q <= stall_d;  err_q <= err_d;  valid_q <= valid_d;
            addr_q <= addr_d;  wdata_q <= wdata_d;
            wb_q <= wb_d;  md_q <= md_d;  hi_q <= hi_d;  lo_q <= lo_d;  inst_q <= inst_d;
            wb_lat_q <= wb_lat_d;  hi_lat_q <= hi_lat_d;  inst_lat_q <= inst_lat_d;
            byte_lat_q <= byte_lat_d;  sext_lat_q <= sext_lat_d;  wr_lat_q <= wr_lat_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign wb_ctrl_out  = wb_q;
    assign mem_data_out = md_q;
    assign alu_hi_out   = hi_q;
    assign alu_lo_out   = lo_q;
    assign inst_out     = inst_q;
    assign out_valid    = valid_q;
    assign stall_out    = stall_q;
    assign mem_err      = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes expected MEM/WB results, monitor pops on out_valid.
module tb_mem_access_stage;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst, halt, in_valid, dmem_ack;
    logic [15:0] wb_ctrl_in, mem_ctrl_in, alu_hi_in, alu_lo_in, store_data_in, inst_in, dmem_rdata;
    logic        dmem_req, dmem_we, out_valid, stall_out, mem_err;
    logic [15:0] dmem_addr, dmem_wdata, wb_ctrl_out, mem_data_out, alu_hi_out, alu_lo_out, inst_out;

    typedef struct packed {
        logic [15:0] wb;
        logic [15:0] md;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [15:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .halt(halt), .in_valid(in_valid),
        .wb_ctrl_in(wb_ctrl_in), .mem_ctrl_in(mem_ctrl_in), .alu_hi_in(alu_hi_in),
        .alu_lo_in(alu_lo_in), .store_data_in(store_data_in), .inst_in(inst_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_ctrl_out(wb_ctrl_out), .mem_data_out(mem_data_out), .alu_hi_out(alu_hi_out),
        .alu_lo_out(alu_lo_out), .inst_out(inst_out),
        .out_valid(out_valid), .stall_out(stall_out), .mem_err(mem_err)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: load result from the access rules, expressed with plain arithmetic.
    function automatic logic [15:0] model_rd(input logic [15:0] ctrl, input logic [15:0] addr,
                                             input logic [15:0] rd);
        int unsigned r, b;
        r = rd;
        if (ctrl[1] || !ctrl[0]) return 16'h0000;
        if (!ctrl[2]) return rd;
        b = (r >> (addr[0] ? 8 : 0)) % 256;
        if (ctrl[3] && b >= 128) b = b + 65280;
        return 16'(b);
    endfunction

    function automatic logic [15:0] model_wd(input logic [15:0] ctrl, input logic [15:0] sd);
        int unsigned s;
        s = sd;
        return ctrl[2] ? 16'((s % 256) * 257) : sd;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 16'(out_valid), 16'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_ctrl_out", wb_ctrl_out, e.wb);
                chk("mem_data_out", mem_data_out, e.md);
                chk("alu_hi_out", alu_hi_out, e.hi);
                chk("alu_lo_out", alu_lo_out, e.lo);
                chk("inst_out", inst_out, e.inst);
                $display("txn lo=%h md=%h inst=%h", alu_lo_out, mem_data_out, inst_out);
            end
        end
    end

    task automatic scramble();
        wb_ctrl_in = 16'($urandom); mem_ctrl_in = 16'($urandom); alu_hi_in = 16'($urandom);
        alu_lo_in = 16'($urandom); store_data_in = 16'($urandom); inst_in = 16'($urandom);
        dmem_rdata = 16'($urandom);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"}, 16'(dmem_req), 16'h0);
        chk({tag, "_we"}, 16'(dmem_we), 16'h0);
        chk({tag, "_addr"}, dmem_addr, 16'h0);
        chk({tag, "_wdata"}, dmem_wdata, 16'h0);
        chk({tag, "_wb"}, wb_ctrl_out, 16'h0);
        chk({tag, "_md"}, mem_data_out, 16'h0);
        chk({tag, "_hi"}, alu_hi_out, 16'h0);
        chk({tag, "_lo"}, alu_lo_out, 16'h0);
        chk({tag, "_inst"}, inst_out, 16'h0);
        chk({tag, "_valid"}, 16'(out_valid), 16'h0);
        chk({tag, "_stall"}, 16'(stall_out), 16'h0);
        chk({tag, "_err"}, 16'(mem_err), 16'h0);
    endtask

    // Issue one instruction at a negedge; dly = idle ACCESS cycles before ack (kept below TO).
    task automatic do_txn(input logic [15:0] wb, input logic [15:0] ctrl, input logic [15:0] hi,
                          input logic [15:0] lo, input logic [15:0] sd, input logic [15:0] inst,
                          input logic [15:0] rd, input int dly);
        exp_t e;
        e = '{wb: wb, md: 16'h0000, hi: hi, lo: lo, inst: inst};
        wb_ctrl_in = wb; mem_ctrl_in = ctrl; alu_hi_in = hi; alu_lo_in = lo;
        store_data_in = sd; inst_in = inst; in_valid = 1'b1; halt = 1'b0; dmem_ack = 1'b0;
        if (!ctrl[0] && !ctrl[1]) begin
            exp_q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
            chk("req_nonmem", 16'(dmem_req), 16'h0);
            chk("stall_nonmem", 16'(stall_out), 16'h0);
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
            scramble();
            chk("req_start", 16'(dmem_req), 16'h1);
            chk("we", 16'(dmem_we), 16'(ctrl[1]));
            chk("addr", dmem_addr, lo);
            if (ctrl[1]) chk("wdata", dmem_wdata, model_wd(ctrl, sd));
            for (int i = 0; i < dly; i++) begin
                chk("stall_wait", 16'(stall_out), 16'h1);
                chk("addr_hold", dmem_addr, lo);
                halt = 1'($urandom);
                @(negedge clk);
            end
            chk("stall_ack", 16'(stall_out), 16'h1);
            chk("req_ack", 16'(dmem_req), 16'h1);
            dmem_ack = 1'b1;
            dmem_rdata = rd;
            e.md = model_rd(ctrl, lo, rd);
            exp_q.push_back(e);
            @(negedge clk);
            dmem_ack = 1'b0;
            halt = 1'b0;
            chk("stall_done", 16'(stall_out), 16'h0);
            chk("req_done", 16'(dmem_req), 16'h0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; halt = 1'b0; in_valid = 1'b0; dmem_ack = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Pass-through, word read with ack on the last allowed cycle, byte reads, byte write.
        do_txn(16'h0011, 16'h0000, 16'h5678, 16'h1234, 16'h9999, 16'hA001, 16'h0, 0);
        do_txn(16'h0022, 16'h0001, 16'h0001, 16'h0010, 16'h0000, 16'hA002, 16'hBEEF, 3);
        do_txn(16'h0033, 16'h000D, 16'h0002, 16'h0011, 16'h0000, 16'hA003, 16'h80FF, 1);
        do_txn(16'h0044, 16'h0005, 16'h0003, 16'h0011, 16'h0000, 16'hA004, 16'h80FF, 0);
        do_txn(16'h0055, 16'h0006, 16'h0004, 16'h0020, 16'h00A5, 16'hA005, 16'h1234, 2);

        // Halted acceptance and stray acks in IDLE must produce nothing.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; halt = 1'b1; mem_ctrl_in = 16'h0001; dmem_ack = 1'b1;
            @(negedge clk);
            chk("halt_req", 16'(dmem_req), 16'h0);
            chk("halt_stall", 16'(stall_out), 16'h0);
        end
        in_valid = 1'b0; halt = 1'b0; dmem_ack = 1'b0;

        for (int n = 0; n < 80; n++) begin
            logic [15:0] c;
            c = 16'($urandom);
            if ($urandom_range(0, 3) == 0) c[1:0] = 2'b00;
            do_txn(16'($urandom), c, 16'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom), int'($urandom_range(0, TO - 1)));
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                in_valid = 1'($urandom); halt = 1'b1; dmem_ack = 1'($urandom);
                scramble();
                @(negedge clk);
            end
            in_valid = 1'b0; halt = 1'b0; dmem_ack = 1'b0;
        end

        // Timeout: no ack for TO ACCESS cycles.
        mem_ctrl_in = 16'h0001; alu_lo_in = 16'h0040; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < int'(TO); i++) begin
            chk("to_req", 16'(dmem_req), 16'h1);
            chk("to_err_early", 16'(mem_err), 16'h0);
            @(negedge clk);
        end
        chk("to_err", 16'(mem_err), 16'h1);
        chk("to_req_drop", 16'(dmem_req), 16'h0);
        for (int i = 0; i < 3; i++) begin
            chk("err_stall", 16'(stall_out), 16'h1);
            in_valid = 1'b1; mem_ctrl_in = 16'h0000; dmem_ack = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0; dmem_ack = 1'b0;
        chk("err_sticky", 16'(mem_err), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err_clear", 16'(mem_err), 16'h0);
        chk("err_stall_clear", 16'(stall_out), 16'h0);

        // Reset while a write is outstanding.
        mem_ctrl_in = 16'h0002; alu_lo_in = 16'h0077; store_data_in = 16'h3C3C;
        wb_ctrl_in = 16'h1111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_req", 16'(dmem_req), 16'h1);
        chk("mid_we", 16'(dmem_we), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid_reset");
        do_txn(16'h0066, 16'h0000, 16'h0005, 16'h0abc, 16'h0, 16'hA006, 16'h0, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 16'(exp_q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum cycles to wait for dmem_ack before flagging an error (range 1..255).
REQ-002 SHALL have ports, clock and reset first: clk in 1, the single clock, all logic on its rising edge; rst in 1, reset, synchronous, active-high.
REQ-003 SHALL have port halt in 1: active-high freeze of new-instruction acceptance.
REQ-004 SHALL have port in_valid in 1: EX/MEM buffer outputs hold a valid instruction.
REQ-005 SHALL have ports wb_ctrl_in, mem_ctrl_in, alu_hi_in, alu_lo_in, store_data_in, inst_in, each in 16: the EX/MEM buffer outputs.
REQ-006 SHALL have port dmem_req out 1: memory request, held high until ack.
REQ-007 SHALL have ports dmem_we out 1 (write enable), dmem_addr out 16, dmem_wdata out 16, dmem_rdata in 16, dmem_ack in 1 (one-cycle completion pulse).
REQ-008 SHALL have ports wb_ctrl_out, mem_data_out, alu_hi_out, alu_lo_out, inst_out, each out 16: registered MEM/WB outputs.
REQ-009 SHALL have ports out_valid out 1, stall_out out 1 (upstream must hold its inputs) and mem_err out 1 (sticky timeout flag).

Function
REQ-010 SHALL decode mem_ctrl_in as follows: bit0 read, bit1 write, bit2 byte access, bit3 sign-extend byte; bits 15:4 ignored; bit0 and bit1 both set treated as write only.
REQ-011 SHALL implement FSM states IDLE, ACCESS and ERROR.
REQ-012 In IDLE with in_valid=1, halt=0 and no memory op, SHALL register all outputs with mem_data_out=0 and out_valid=1 the next cycle (latency 1).
REQ-013 In IDLE with in_valid=1, halt=0 and a memory op, SHALL latch the inputs, move to ACCESS and set stall_out=1 and dmem_req=1 from the next cycle.
REQ-014 SHALL drive dmem_addr=alu_lo_in, dmem_wdata=store_data_in and dmem_we=write, all stable throughout ACCESS.
REQ-015 In ACCESS, dmem_ack=1 SHALL cause, on the next cycle: dmem_req=0, stall_out=0, out_valid=1, mem_data_out=read data (0 for writes), return to IDLE.
REQ-016 For a byte read, mem_data_out SHALL take dmem_addr[0]=0 → rdata[7:0], else rdata[15:8], zero- or sign-extended per bit3.
REQ-017 For a byte write, SHALL drive dmem_wdata = {store_data_in[7:0], store_data_in[7:0]}.
REQ-018 SHALL clear out_valid after one cycle unless a new result is registered; other outputs hold their last value.
REQ-019 SHALL increment an 8-bit wait counter each ACCESS cycle without ack; when the count reaches TIMEOUT, SHALL enter ERROR, set mem_err=1 and drop dmem_req.
REQ-020 In ERROR, stall_out SHALL stay 1 and out_valid 0 until rst.
REQ-021 halt SHALL affect only IDLE acceptance; an ACCESS already in progress SHALL complete normally.
REQ-022 SHALL ignore dmem_ack outside ACCESS.
REQ-023 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL take priority, with no error raised.
REQ-024 In IDLE with in_valid=0, SHALL register nothing new.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE and counter=0.
REQ-026 rst=1 at a clock edge SHALL clear all outputs: 16-bit outputs 0000h, out_valid, stall_out, dmem_req, dmem_we and mem_err all 0.
REQ-027 rst SHALL override any in-flight ACCESS; the request is abandoned without a memory write completing from this block.

Structure
REQ-028 SHALL place the mem_ctrl bit-position constants and the FSM state encoding in the shared package pipeline_pkg.
REQ-029 SHALL contain one sub-module, mem_byte_align, implementing byte select/extension for reads and byte replication for writes.

Verification
REQ-030 Scenario: mem_ctrl=0000h, alu_lo=1234h → next cycle out_valid=1, alu_lo_out=1234h, dmem_req never 1.
REQ-031 Scenario: word read, addr 0010h, ack after 3 cycles with rdata BEEFh → stall_out=1 for 4 cycles, then mem_data_out=BEEFh.
REQ-032 Scenario: signed byte read, addr 0011h, rdata 80FFh → mem_data_out=FF80h; same access unsigned → 0080h.
REQ-033 Scenario: byte write of 00A5h → dmem_wdata=A5A5h, dmem_we=1, then mem_data_out=0000h.
REQ-034 Scenario: no ack, TIMEOUT=4 → mem_err=1 after 4 ACCESS cycles, stall_out stays 1; rst clears both.
REQ-035 Scenario: rst asserted mid-ACCESS → next cycle dmem_req=0, all outputs 0; halt=1 in IDLE with in_valid=1 → no dmem_req, out_valid=0.
